register_rtl: RTL and testbench

REGISTER_RTL -- requirements
Module: register_rtl

---
 rtl/register_rtl.sv | 26 ++
 tb/tb_register_rtl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/register_rtl.sv
// Parameterised p_nbits-wide storage register: synchronous active-low clear,
// active-high load enable, output driven straight from the flip-flops.
module register_rtl #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    logic [p_nbits-1:0] q_reg;

    // Clear beats load; with neither, the flops simply hold (clock-enable style).
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: tb/tb_register_rtl.sv
// Directed-vector and randomised checks of register_rtl at widths 1, 5 and 13,
// all three instances driven from the same stimulus (narrower ones see low bits of d).
module tb_register_rtl;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic [12:0] d;
        logic [12:0] exp_q;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [12:0] d = '0;
    logic [0:0]  q1;
    logic [4:0]  q5;
    logic [12:0] q13;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vec_t        vecs[64];
    int          nv = 0;
    logic [12:0] model_q;

    always #5 clk = ~clk;

    register_rtl #(.p_nbits(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .d(d[0:0]), .q(q1)
    );
    register_rtl #(.p_nbits(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .d(d[4:0]), .q(q5)
    );
    register_rtl #(.p_nbits(13)) dut13 (
        .clk(clk), .rst(rst), .en(en), .d(d), .q(q13)
    );

    task automatic check(input string nm, input int w, input logic [12:0] act,
                         input logic [12:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s w=%0d: q=0x%0h expected 0x%0h", nm, w, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_all(input string nm, input logic [12:0] exp);
        check(nm, 1, {12'b0, q1}, {12'b0, exp[0]});
        check(nm, 5, {8'b0, q5}, {8'b0, exp[4:0]});
        check(nm, 13, q13, exp);
    endtask

    task automatic add_vec(input string nm, input logic r, input logic e,
                           input logic [12:0] dv, input logic [12:0] ev);
        vecs[nv].name  = nm;
        vecs[nv].rst   = r;
        vecs[nv].en    = e;
        vecs[nv].d     = dv;
        vecs[nv].exp_q = ev;
        nv++;
    endtask

    // Drive inputs, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [12:0] dv);
        rst = r;
        en  = e;
        d   = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then the 1-bit basic path
        add_vec("reset",      1'b0, 1'b0, 13'h0000, 13'h0000);
        add_vec("basic0",     1'b1, 1'b1, 13'h0000, 13'h0000);
        add_vec("basic1",     1'b1, 1'b1, 13'h0001, 13'h0001);
        add_vec("basic2",     1'b1, 1'b1, 13'h0000, 13'h0000);
        add_vec("basic3",     1'b1, 1'b1, 13'h0000, 13'h0000);
        for (int i = 0; i < 16; i++) begin
            add_vec("count", 1'b1, 1'b1, 13'(i), 13'(i));
        end
        add_vec("count_end",  1'b1, 1'b1, 13'h0000, 13'h0000);
        // Enable hold
        add_vec("hold_ld3",   1'b1, 1'b1, 13'h0003, 13'h0003);
        add_vec("hold_ldC",   1'b1, 1'b1, 13'h000C, 13'h000C);
        add_vec("hold_F",     1'b1, 1'b0, 13'h000F, 13'h000C);
        add_vec("hold_0",     1'b1, 1'b0, 13'h0000, 13'h000C);
        add_vec("hold_F2",    1'b1, 1'b0, 13'h000F, 13'h000C);
        add_vec("hold_ldF",   1'b1, 1'b1, 13'h000F, 13'h000F);
        // Reset priority over enable, then with enable low
        add_vec("pri_ldC",    1'b1, 1'b1, 13'h000C, 13'h000C);
        add_vec("pri_en1_a",  1'b0, 1'b1, 13'h000F, 13'h0000);
        add_vec("pri_en1_b",  1'b0, 1'b1, 13'h000F, 13'h0000);
        add_vec("pri_en1_c",  1'b0, 1'b1, 13'h000F, 13'h0000);
        add_vec("pri_ldC2",   1'b1, 1'b1, 13'h000C, 13'h000C);
        add_vec("pri_en0_a",  1'b0, 1'b0, 13'h000F, 13'h0000);
        add_vec("pri_en0_b",  1'b0, 1'b0, 13'h000F, 13'h0000);
        add_vec("pri_en0_c",  1'b0, 1'b0, 13'h000F, 13'h0000);
        add_vec("rel_hold3",  1'b1, 1'b0, 13'h0003, 13'h0000);
        add_vec("rel_hold1F", 1'b1, 1'b0, 13'h1FFF, 13'h0000);
        add_vec("rel_load",   1'b1, 1'b1, 13'h1ABC, 13'h1ABC);
        add_vec("bits_1555",  1'b1, 1'b1, 13'h1555, 13'h1555);
        add_vec("bits_0AAA",  1'b1, 1'b1, 13'h0AAA, 13'h0AAA);
        // Reset in the middle of a run of loads
        add_vec("run_111",    1'b1, 1'b1, 13'h0111, 13'h0111);
        add_vec("run_222",    1'b1, 1'b1, 13'h0222, 13'h0222);
        add_vec("run_rst",    1'b0, 1'b1, 13'h0333, 13'h0000);
        add_vec("run_444",    1'b1, 1'b1, 13'h0444, 13'h0444);

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].d);
            check_all(vecs[i].name, vecs[i].exp_q);
        end

        // Reset asserted between edges must not touch q until the next edge
        step(1'b1, 1'b1, 13'h10F1);
        check_all("mid_load", 13'h10F1);
        #2;
        rst = 1'b0;
        en  = 1'b1;
        d   = 13'h0FFF;
        #1;
        check_all("mid_rst_before_edge", 13'h10F1);
        @(posedge clk);
        #1;
        check_all("mid_rst_after_edge", 13'h0000);
        step(1'b1, 1'b0, 13'h0F0F);
        check_all("mid_rel_hold", 13'h0000);

        // Random load/hold, reset held inactive
        model_q = 13'h0000;
        for (int i = 0; i < 50; i++) begin
            logic        re;
            logic [12:0] rd;
            re = 1'($urandom_range(0, 1));
            rd = 13'($urandom_range(0, 8191));
            step(1'b1, re, rd);
            if (re) model_q = rd;
            check_all("rand_ld", model_q);
        end

        // Random with reset; sample just before each rising edge
        for (int i = 0; i < 50; i++) begin
            logic        rr;
            logic        re;
            logic [12:0] rd;
            rr = ($urandom_range(0, 3) != 0);
            re = 1'($urandom_range(0, 1));
            rd = 13'($urandom_range(0, 8191));
            rst = rr;
            en  = re;
            d   = rd;
            @(posedge clk);
            if (!rr) model_q = 13'h0000;
            else if (re) model_q = rd;
            @(negedge clk);
            #3;
            check_all("rand_rst", model_q);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
